// File: rtl/bch_enc_sched.sv
// Two-requester scheduler and bit-serial systematic encoder for BCH(63,56).
// Round-robin picks a requester, shifts its message MSB-first through a
// 7-bit parity LFSR one bit per cycle, then holds {msg, parity} on a
// valid/ready output until the sink takes it.
module bch_enc_sched #(
    parameter int unsigned K     = 56,
    parameter logic [6:0]  GPOLY = 7'b1000101
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    input  logic [K-1:0]   req0_data,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [K-1:0]   req1_data,
    output logic           req1_ready,
    input  logic           flush,
    output logic           cw_valid,
    output logic [K+6:0]   cw_data,
    output logic           cw_src,
    input  logic           cw_ready,
    output logic           busy
);

    localparam int unsigned CntW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e          state_q, state_d;

    logic [K-1:0]    msg_q;
    logic [K-1:0]    shift_q;
    logic [6:0]      lfsr_q;
    logic [6:0]      lfsr_d;
    logic [CntW-1:0] cnt_q;
    logic            src_q;
    logic            rr_last_q;
    logic [K+6:0]    cw_data_q;

    logic            grant;
    logic            grant_vld;
    logic            accept;
    logic            fb;
    logic            last_shift;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept)     state_d = StShift;
            StShift: if (last_shift) state_d = StDone;
            StDone:  if (cw_ready)   state_d = StIdle;
            default:                 state_d = StIdle;
        endcase
        if (flush) begin
            state_d = StIdle;
        end
    end

    // Outputs: round-robin grant, requester ready, status
    always_comb begin
        grant     = 1'b0;
        grant_vld = 1'b0;
        if (req0_valid && req1_valid) begin
            // Tie goes to whoever was not served last
            grant     = ~rr_last_q;
            grant_vld = 1'b1;
        end else if (req0_valid) begin
            grant     = 1'b0;
            grant_vld = 1'b1;
        end else if (req1_valid) begin
            grant     = 1'b1;
            grant_vld = 1'b1;
        end
        req0_ready = (state_q == StIdle) && !flush && grant_vld && !grant;
        req1_ready = (state_q == StIdle) && !flush && grant_vld && grant;
        cw_valid   = (state_q == StDone);
        busy       = (state_q != StIdle);
    end

    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign last_shift = (state_q == StShift) && (cnt_q == '0);

    // Parity LFSR next value for the bit currently leaving the shift register
    always_comb begin
        fb     = lfsr_q[6] ^ shift_q[K-1];
        lfsr_d = {lfsr_q[5:0], 1'b0} ^ ({7{fb}} & GPOLY);
    end

    // Job datapath: message capture, serial shift, parity accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_q     <= '0;
            shift_q   <= '0;
            lfsr_q    <= '0;
            cnt_q     <= '0;
            src_q     <= 1'b0;
            rr_last_q <= 1'b1;
        end else if (flush) begin
            // Abandon the job; the arbitration history is kept
            lfsr_q <= '0;
        end else if (accept) begin
            msg_q     <= grant ? req1_data : req0_data;
            shift_q   <= grant ? req1_data : req0_data;
            lfsr_q    <= '0;
            cnt_q     <= CntW'(K - 1);
            src_q     <= grant;
            rr_last_q <= grant;
        end else if (state_q == StShift) begin
            shift_q <= {shift_q[K-2:0], 1'b0};
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_q - 1'b1;
        end
    end

    // Codeword register is only written with a complete result, so a
    // flushed or reset job never leaks a partial parity onto cw_data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cw_data_q <= '0;
        end else if (!flush && last_shift) begin
            cw_data_q <= {msg_q, lfsr_d};
        end
    end

    assign cw_data = cw_data_q;
    assign cw_src  = src_q;

endmodule
